// File: rtl/mc_response_analyzer.sv
// March C response analyzer: drives the SRAM from the March C counter word and
// compares every read against the expected data background two cycles later.
module mc_response_analyzer #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 4,
  parameter int PATTERN_WIDTH = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic [ADDR_WIDTH+PATTERN_WIDTH:0]   tst_word,
  input  logic                                mc_done,
  input  logic [DATA_WIDTH-1:0]               sram_dout,
  output logic                                sram_cs,
  output logic                                sram_we,
  output logic [ADDR_WIDTH-1:0]               sram_addr,
  output logic [DATA_WIDTH-1:0]               sram_din,
  output logic                                fail,
  output logic [ADDR_WIDTH:0]                 fail_count,
  output logic [ADDR_WIDTH-1:0]               first_fail_addr,
  output logic [DATA_WIDTH-1:0]               first_fail_data,
  output logic                                done,
  output logic                                pass
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            r_state;
  logic                  r_drainCnt;

  logic                  r_cs;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_din;

  logic                  r_aValid;
  logic [ADDR_WIDTH-1:0] r_aAddr;
  logic [DATA_WIDTH-1:0] r_aExp;
  logic                  r_bValid;
  logic [ADDR_WIDTH-1:0] r_bAddr;
  logic [DATA_WIDTH-1:0] r_bExp;

  logic                  r_fail;
  logic [ADDR_WIDTH:0]   r_failCount;
  logic [ADDR_WIDTH-1:0] r_firstAddr;
  logic [DATA_WIDTH-1:0] r_firstData;
  logic                  r_done;
  logic                  r_pass;

  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_we;
  logic                  w_bg;
  logic [DATA_WIDTH-1:0] w_bgWord;
  logic                  w_issue;
  logic                  w_isRead;
  logic                  w_mismatch;

  assign w_addr     = tst_word[ADDR_WIDTH-1:0];
  assign w_we       = tst_word[ADDR_WIDTH];
  assign w_bg       = tst_word[ADDR_WIDTH+1];
  assign w_bgWord   = {DATA_WIDTH{w_bg}};
  assign w_issue    = (r_state == S_RUN) && en;
  assign w_isRead   = w_issue && !w_we;
  assign w_mismatch = r_bValid && (sram_dout != r_bExp);

  // mc_done seen while idle means an empty run: skip straight to the drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_drainCnt <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mc_done) begin
            r_state    <= S_DRAIN;
            r_drainCnt <= 1'b0;
          end else if (en) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (mc_done) begin
            r_state    <= S_DRAIN;
            r_drainCnt <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (r_drainCnt) begin
            r_state <= S_DONE;
          end else begin
            r_drainCnt <= 1'b1;
          end
        end
        S_DONE: r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cs   <= 1'b0;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_din  <= '0;
    end else begin
      r_cs <= w_issue;
      r_we <= w_issue && w_we;
      if (w_issue) begin
        r_addr <= w_addr;
        r_din  <= w_bgWord;
      end
    end
  end

  // Stage A is loaded with the read itself, stage B lines up with sram_dout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_aValid <= 1'b0;
      r_aAddr  <= '0;
      r_aExp   <= '0;
      r_bValid <= 1'b0;
      r_bAddr  <= '0;
      r_bExp   <= '0;
    end else begin
      r_aValid <= w_isRead;
      if (w_isRead) begin
        r_aAddr <= w_addr;
        r_aExp  <= w_bgWord;
      end
      r_bValid <= r_aValid;
      r_bAddr  <= r_aAddr;
      r_bExp   <= r_aExp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fail      <= 1'b0;
      r_failCount <= '0;
      r_firstAddr <= '0;
      r_firstData <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      if (w_mismatch) begin
        r_fail <= 1'b1;
        if (!(&r_failCount)) begin
          r_failCount <= r_failCount + 1'b1;
        end
        if (!r_fail) begin
          r_firstAddr <= r_bAddr;
          r_firstData <= sram_dout;
        end
      end
      r_done <= (r_state == S_DONE);
      r_pass <= (r_state == S_DONE) && !r_fail;
    end
  end

  assign sram_cs         = r_cs;
  assign sram_we         = r_we;
  assign sram_addr       = r_addr;
  assign sram_din        = r_din;
  assign fail            = r_fail;
  assign fail_count      = r_failCount;
  assign first_fail_addr = r_firstAddr;
  assign first_fail_data = r_firstData;
  assign done            = r_done;
  assign pass            = r_pass;

endmodule

// File: tb/tb_mc_response_analyzer.sv
// Bench for mc_response_analyzer: a fault-injecting 256x4 SRAM model plus a
// cycle-level reference built from queued reads, checked every cycle.
module tb_mc_response_analyzer;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [9:0] tst_word;
  logic       mc_done;
  logic [3:0] sram_dout;
  logic       sram_cs;
  logic       sram_we;
  logic [7:0] sram_addr;
  logic [3:0] sram_din;
  logic       fail;
  logic [8:0] fail_count;
  logic [7:0] first_fail_addr;
  logic [3:0] first_fail_data;
  logic       done;
  logic       pass;

  mc_response_analyzer #(.ADDR_WIDTH(8), .DATA_WIDTH(4), .PATTERN_WIDTH(1)) dut (
    .clk(clk), .rst(rst), .en(en), .tst_word(tst_word), .mc_done(mc_done),
    .sram_dout(sram_dout), .sram_cs(sram_cs), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_din(sram_din), .fail(fail),
    .fail_count(fail_count), .first_fail_addr(first_fail_addr),
    .first_fail_data(first_fail_data), .done(done), .pass(pass)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // SRAM fault configuration, only changed while the DUT is held in reset.
  int         faultAddr = -1;
  logic [3:0] stuck1    = 4'h0;
  logic [3:0] stuck0    = 4'h0;
  logic       invertAll = 1'b0;

  function automatic logic [3:0] faultRead(input logic [7:0] a, input logic [3:0] d);
    logic [3:0] r;
    r = d;
    if (int'(a) == faultAddr) r = (r | stuck1) & ~stuck0;
    if (invertAll) r = ~r;
    return r;
  endfunction

  logic [3:0] mem [256];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 4'h0;
    end else if (sram_cs) begin
      if (sram_we) mem[sram_addr] <= sram_din;
      else         sram_dout <= faultRead(sram_addr, mem[sram_addr]);
    end
  end

  // Reference model: phases of the run plus a queue of reads awaiting compare.
  localparam int PH_IDLE  = 0;
  localparam int PH_RUN   = 1;
  localparam int PH_DRAIN = 2;
  localparam int PH_DONE  = 3;

  typedef struct {
    int         due;
    logic [7:0] addr;
    logic [3:0] exp;
    logic [3:0] got;
  } rd_t;

  rd_t        pending[$];
  logic [3:0] modelMem [256];
  int         mPhase = PH_IDLE;
  int         drainLeft = 0;
  int         mCount = 0;
  logic       mCs = 0, mWe = 0, mFail = 0, mDone = 0, mPass = 0;
  logic [7:0] mAddr = 0, mFirstAddr = 0;
  logic [3:0] mDin = 0, mFirstData = 0;

  task automatic modelStep();
    logic nDone;
    logic nPass;
    rd_t  e;
    if (rst) begin
      mPhase = PH_IDLE; drainLeft = 0; mCount = 0;
      mCs = 0; mWe = 0; mFail = 0; mDone = 0; mPass = 0;
      mAddr = 0; mDin = 0; mFirstAddr = 0; mFirstData = 0;
      pending.delete();
      for (int i = 0; i < 256; i++) modelMem[i] = 4'h0;
      return;
    end
    nDone = (mPhase == PH_DONE);
    nPass = nDone && !mFail;
    if (pending.size() > 0 && pending[0].due == cyc) begin
      e = pending.pop_front();
      if (e.got != e.exp) begin
        if (!mFail) begin
          mFirstAddr = e.addr;
          mFirstData = e.got;
        end
        mFail = 1'b1;
        if (mCount < 511) mCount++;
      end
    end
    if (mPhase == PH_RUN && en) begin
      mCs   = 1'b1;
      mWe   = tst_word[8];
      mAddr = tst_word[7:0];
      mDin  = {4{tst_word[9]}};
      if (mWe) begin
        modelMem[mAddr] = mDin;
      end else begin
        e.due  = cyc + 2;
        e.addr = mAddr;
        e.exp  = mDin;
        e.got  = faultRead(mAddr, modelMem[mAddr]);
        pending.push_back(e);
      end
    end else begin
      mCs = 1'b0;
      mWe = 1'b0;
    end
    case (mPhase)
      PH_IDLE:  if (mc_done) begin mPhase = PH_DRAIN; drainLeft = 2; end
                else if (en) mPhase = PH_RUN;
      PH_RUN:   if (mc_done) begin mPhase = PH_DRAIN; drainLeft = 2; end
      PH_DRAIN: begin
        drainLeft--;
        if (drainLeft == 0) mPhase = PH_DONE;
      end
      default:  mPhase = PH_DONE;
    endcase
    mDone = nDone;
    mPass = nPass;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, observed, expected);
    end
  endtask

  task automatic checkAll();
    checkOutput("sram_cs", 32'(sram_cs), 32'(mCs));
    checkOutput("sram_we", 32'(sram_we), 32'(mWe));
    checkOutput("sram_addr", 32'(sram_addr), 32'(mAddr));
    checkOutput("sram_din", 32'(sram_din), 32'(mDin));
    checkOutput("fail", 32'(fail), 32'(mFail));
    checkOutput("fail_count", 32'(fail_count), mCount);
    checkOutput("first_fail_addr", 32'(first_fail_addr), 32'(mFirstAddr));
    checkOutput("first_fail_data", 32'(first_fail_data), 32'(mFirstData));
    checkOutput("done", 32'(done), 32'(mDone));
    checkOutput("pass", 32'(pass), 32'(mPass));
  endtask

  task automatic applyStimulus(input logic iRst, input logic iEn, input logic iDone, input logic [9:0] iWord);
    rst      = iRst;
    en       = iEn;
    mc_done  = iDone;
    tst_word = iWord;
    @(posedge clk);
    cyc++;
    modelStep();
    #1;
    checkAll();
  endtask

  function automatic logic [9:0] mkWord(input logic bg, input logic we, input int a);
    return {bg, we, 8'(a)};
  endfunction

  task automatic resetDut();
    applyStimulus(1'b1, 1'b0, 1'b0, 10'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 10'h0);
  endtask

  task automatic idleUntilDone(input int n, output int doneAt);
    doneAt = -1;
    for (int k = 1; k <= n; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 10'h0);
      if (done === 1'b1 && doneAt < 0) doneAt = k;
    end
  endtask

  task automatic runMarchC(output int doneAt);
    logic [9:0] words[$];
    for (int a = 0; a < 256; a++) words.push_back(mkWord(1'b0, 1'b1, a));
    for (int a = 0; a < 256; a++) begin
      words.push_back(mkWord(1'b0, 1'b0, a)); words.push_back(mkWord(1'b1, 1'b1, a));
    end
    for (int a = 0; a < 256; a++) begin
      words.push_back(mkWord(1'b1, 1'b0, a)); words.push_back(mkWord(1'b0, 1'b1, a));
    end
    for (int a = 255; a >= 0; a--) begin
      words.push_back(mkWord(1'b0, 1'b0, a)); words.push_back(mkWord(1'b1, 1'b1, a));
    end
    for (int a = 255; a >= 0; a--) begin
      words.push_back(mkWord(1'b1, 1'b0, a)); words.push_back(mkWord(1'b0, 1'b1, a));
    end
    for (int a = 0; a < 256; a++) words.push_back(mkWord(1'b0, 1'b0, a));
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h0);
    for (int i = 0; i < words.size(); i++)
      applyStimulus(1'b0, 1'b1, (i == words.size() - 1), words[i]);
    idleUntilDone(5, doneAt);
  endtask

  initial begin
    int doneAt;
    rst = 1'b1; en = 1'b0; mc_done = 1'b0; tst_word = 10'h0;

    resetDut();
    checkOutput("rst_cs", 32'(sram_cs), 0);
    checkOutput("rst_fail_count", 32'(fail_count), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_pass", 32'(pass), 0);

    $display("[TB] fault-free March C");
    runMarchC(doneAt);
    checkOutput("clean_done_latency", doneAt, 3);
    checkOutput("clean_pass", 32'(pass), 1);
    checkOutput("clean_fail", 32'(fail), 0);
    checkOutput("clean_count", 32'(fail_count), 0);

    $display("[TB] March C with bit 2 of 0x5A stuck at 1");
    faultAddr = 'h5A; stuck1 = 4'b0100; stuck0 = 4'b0000;
    resetDut();
    runMarchC(doneAt);
    checkOutput("sa1_fail", 32'(fail), 1);
    checkOutput("sa1_first_addr", 32'(first_fail_addr), 'h5A);
    checkOutput("sa1_first_data", 32'(first_fail_data), 4'b0100);
    checkOutput("sa1_count", 32'(fail_count), 3);
    checkOutput("sa1_pass", 32'(pass), 0);

    $display("[TB] single read of 0x10 returning 4'hE");
    faultAddr = 'h10; stuck1 = 4'h0; stuck0 = 4'b0001;
    resetDut();
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, mkWord(1'b1, 1'b1, 'h10));
    applyStimulus(1'b0, 1'b1, 1'b0, mkWord(1'b1, 1'b0, 'h10));
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h0);
    checkOutput("e1_fail_low", 32'(fail), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h0);
    checkOutput("e2_fail_high", 32'(fail), 1);
    checkOutput("e2_first_data", 32'(first_fail_data), 4'hE);
    checkOutput("e2_first_addr", 32'(first_fail_addr), 'h10);
    applyStimulus(1'b0, 1'b0, 1'b1, 10'h0);
    idleUntilDone(4, doneAt);
    checkOutput("e2_count", 32'(fail_count), 1);

    $display("[TB] saturating mismatch count");
    faultAddr = -1; stuck0 = 4'h0; invertAll = 1'b1;
    resetDut();
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h0);
    for (int i = 0; i < 1024; i++)
      applyStimulus(1'b0, 1'b1, (i == 1023), mkWord(1'b0, 1'b0, int'($urandom_range(0, 255))));
    idleUntilDone(4, doneAt);
    checkOutput("sat_count", 32'(fail_count), 511);

    $display("[TB] reset with a mismatching read in flight");
    for (int d = 1; d <= 2; d++) begin
      resetDut();
      applyStimulus(1'b0, 1'b1, 1'b0, 10'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, mkWord(1'b0, 1'b0, 3));
      for (int k = 1; k < d; k++) applyStimulus(1'b0, 1'b0, 1'b0, 10'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 10'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 10'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 10'h0);
      checkOutput("rstflight_fail", 32'(fail), 0);
      checkOutput("rstflight_count", 32'(fail_count), 0);
      applyStimulus(1'b0, 1'b1, 1'b0, mkWord(1'b0, 1'b0, 5));
      checkOutput("rstflight_idle_cs", 32'(sram_cs), 0);
    end

    $display("[TB] en toggling over reads of 0x00..0x03");
    resetDut();
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h0);
    for (int a = 0; a < 4; a++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, mkWord(1'b0, 1'b0, a));
      applyStimulus(1'b0, 1'b0, 1'b0, mkWord(1'b0, 1'b0, a + 8));
      checkOutput("bubble_cs", 32'(sram_cs), 0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 10'h0);
    idleUntilDone(4, doneAt);
    checkOutput("toggle_compares", 32'(fail_count), 4);
    invertAll = 1'b0;

    $display("[TB] mc_done while idle");
    resetDut();
    applyStimulus(1'b0, 1'b0, 1'b1, 10'h0);
    idleUntilDone(4, doneAt);
    checkOutput("empty_done_latency", doneAt, 3);
    checkOutput("empty_pass", 32'(pass), 1);

    $display("[TB] randomized traffic");
    faultAddr = int'($urandom_range(0, 15));
    stuck1 = 4'($urandom); stuck0 = 4'($urandom);
    resetDut();
    for (int i = 0; i < 2500; i++) begin
      applyStimulus(($urandom_range(0, 127) == 0),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 63) == 0),
                    mkWord(1'($urandom), 1'($urandom), int'($urandom_range(0, 15))));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_response_analyzer.md
MC_RESPONSE_ANALYZER -- requirements
Module: mc_response_analyzer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, SRAM address bits (depth 256).
REQ-002 SHALL have parameter DATA_WIDTH, default 4, SRAM word bits.
REQ-003 SHALL have parameter PATTERN_WIDTH, default 1, data-background select bits; 0 = all-zeros, 1 = all-ones.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port en, input, 1, March C counter enable; tst_word is valid when en=1.
REQ-007 SHALL have port tst_word, input, ADDR_WIDTH+PATTERN_WIDTH+1, counter word: [7:0] addr, [8] we, [9] background.
REQ-008 SHALL have port mc_done, input, 1, counter completion flag (counter cout).
REQ-009 SHALL have port sram_dout, input, DATA_WIDTH, SRAM read data, valid one cycle after the SRAM samples a read.
REQ-010 SHALL have outputs sram_cs (1), sram_we (1), sram_addr (ADDR_WIDTH) and sram_din (DATA_WIDTH), all registered SRAM drive signals.
REQ-011 SHALL have outputs fail (1, sticky), fail_count (ADDR_WIDTH+1, saturating mismatch count), first_fail_addr (ADDR_WIDTH), first_fail_data (DATA_WIDTH, the raw dout), done (1) and pass (1).

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN, DRAIN and DONE.
REQ-013 IDLE -> RUN SHALL occur on the first edge with en=1 and mc_done=0.
REQ-014 RUN -> DRAIN SHALL occur on the edge where mc_done=1 is sampled.
REQ-015 DRAIN SHALL last exactly 2 cycles, then go to DONE; DONE SHALL hold until rst.
REQ-016 In RUN with en=1, at edge E0, SHALL register: sram_cs=1, sram_we=tst_word[8], sram_addr=tst_word[7:0], sram_din = all tst_word[9] replicated over DATA_WIDTH.
REQ-017 With en=0, or in any state other than RUN, SHALL drive sram_cs=0 and sram_we=0; addr and din hold their last values.
REQ-018 A read is issued when sram_cs=1 and sram_we=0 are registered at E0; the SRAM samples it at E1 and sram_dout is valid after E1.
REQ-019 SHALL carry the expected word and address of each read through a 2-deep pipeline (valid, addr, expected); the expected word is background replicated.
REQ-020 At edge E2, SHALL compare sram_dout to the expected word; compare results SHALL be visible after E2, so issue-to-status latency is 2 cycles.
REQ-021 Writes SHALL never be compared.
REQ-022 Back-to-back reads (one per cycle) SHALL be compared independently.
REQ-023 On a mismatch, SHALL set fail=1 and increment fail_count, saturating at 2^(ADDR_WIDTH+1)-1 (no wrap).
REQ-024 first_fail_addr and first_fail_data SHALL be captured only on the first mismatch; later mismatches SHALL not alter them.
REQ-025 Reads still in flight when mc_done rises SHALL be compared during DRAIN.
REQ-026 No new SRAM access SHALL be issued in DRAIN.
REQ-027 On entry to DONE, SHALL set done=1 and pass=~fail; pass SHALL be 0 in all states other than DONE.
REQ-028 An en=0 bubble SHALL insert a non-valid pipeline slot and SHALL not stall or lose in-flight compares.
REQ-029 mc_done=1 sampled in IDLE SHALL go directly to DRAIN with zero reads, ending in pass=1.

Reset
REQ-030 When rst=1 at an edge, SHALL force state=IDLE, clear all pipeline valids and set every output to 0 (sram_* , fail, fail_count, first_fail_addr, first_fail_data, done, pass).
REQ-031 rst SHALL take priority over en and mc_done.
REQ-032 rst asserted mid-RUN or mid-DRAIN SHALL discard in-flight compares; no status update SHALL occur from them.

Verification
REQ-033 Fault-free 256x4 SRAM model, full March C run -> done=1, pass=1, fail=0, fail_count=0, with done following the first mc_done=1 edge by 3 cycles.
REQ-034 Bit 2 of address 0x5A stuck-at-1 -> fail=1, first_fail_addr=0x5A, first_fail_data=4'b0100 (first r0), fail_count=3, pass=0.
REQ-035 Read of 0x10 expecting 4'hF returning 4'hE at E2 -> fail rises the cycle after E2; a write to the same address is never flagged.
REQ-036 Every read forced to mismatch over a 1024-read stream -> fail_count saturates at 511 and holds.
REQ-037 rst pulsed one cycle after a mismatching read is issued -> all outputs 0, fail stays 0, FSM in IDLE.
REQ-038 en toggled 1/0 every cycle during reads of 0x00..0x03 -> exactly 4 compares; sram_cs=0 in bubble cycles.
